alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Sequences one ALU operation per operator transaction: captures operand A, then operand B + command,
//  drives the shared N-bit ALU, then writes the result to the data register bank and a status word to
//  the control register bank via a req/ack write port. Sits between the debounced switches/button and
//  the ALU + register banks, replacing direct switch-to-ALU wiring in the top level.
// PARAMETERS
//  N        8     ALU operand/result width
//  REG_W    32    register bank word width (REG_W >= N+1)
//  ALU_LAT  1     cycles from operand drive to valid alu_result/alu_carry (>=1)
//  NUM_OPS  10    valid commands are 0..NUM_OPS-1; others are errors
//  ACK_TO   255   max cycles to wait for wr_ack before error
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous, active-high reset
//  btn_pulse  in   1      one-cycle strobe, already debounced/edge-detected (center button)
//  sw_data    in   N      operand switches
//  sw_cmd     in   4      command switches
//  sw_acc     in   1      accumulate select (switch15); used only with ALU_SEQ_ACC_EN
//  alu_a      out  N      ALU operand A
//  alu_b      out  N      ALU operand B
//  alu_ctrl   out  4      ALU command
//  alu_result in   N      ALU result
//  alu_carry  in   1      ALU carry-out
//  wr_req     out  1      write request to bank port 1
//  wr_sel     out  1      0 = control bank, 1 = data bank
//  wr_data    out  REG_W  write word
//  wr_ack     in   1      write accepted this cycle
//  busy       out  1      high in every state except IDLE, WAIT_B and ERR
//  err        out  1      high while in ERR
//  seq_cnt    out  8      completed-transaction counter
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; captured A/B/cmd/result registers 0; seq_cnt=0. Reset wins over
//   any event in the same cycle and aborts any state, dropping wr_req on the next edge.
//  IDLE  : btn_pulse -> latch A=sw_data, go WAIT_B.
//  WAIT_B: btn_pulse -> latch B=sw_data, cmd=sw_cmd; cmd>=NUM_OPS -> ERR, else EXEC.
//  EXEC  : alu_a/alu_b/alu_ctrl driven from latches (held from EXEC through WR_CTRL); count ALU_LAT
//          cycles, then sample {alu_carry,alu_result} into result reg, go WR_DATA.
//  WR_DATA: wr_req=1, wr_sel=1, wr_data=zero-extended {carry,result}; held stable until wr_ack;
//          on wr_ack -> WR_CTRL (wr_req drops for exactly one cycle between writes).
//  WR_CTRL: wr_req=1, wr_sel=0, wr_data={zero-pad, seq_cnt+1[7:0], 2'b0, zero, carry, cmd[3:0]},
//          zero = (result==0); on wr_ack -> seq_cnt increments (wraps 255->0), go IDLE.
//  Timeout: ack counter resets on entry to each write state; ACK_TO cycles without wr_ack -> ERR.
//  ERR   : err=1, wr_req=0; btn_pulse -> IDLE (that pulse captures nothing).
//  btn_pulse outside IDLE/WAIT_B/ERR is ignored. wr_ack outside write states is ignored.
//  Latency from WAIT_B pulse to first wr_req: ALU_LAT+1 cycles.
// CONFIGURATION
//  ALU_SEQ_ACC_EN defined: in IDLE, btn_pulse with sw_acc=1 loads A=previous result[N-1:0]
//   (0 after reset) and goes WAIT_B; sw_acc=0 behaves as below.
//  Not defined: sw_acc ignored; A always from sw_data.
// STRUCTURE
//  Shared package: state enum (IDLE,WAIT_B,EXEC,WR_DATA,WR_CTRL,ERR), bank select constants
//   (SEL_CTRL=0, SEL_DATA=1), status-word field offsets, ALU command codes and NUM_OPS.
//  One sub-module: seq_timeout_counter (load/enable/expire) used for ALU_LAT wait and ACK_TO.
// TESTING
//  A=8'h0F, B=8'h01, cmd=ADD, wr_ack 1 cycle after each req -> data word 32'h010, ctrl word
//   seq=1, zero=0, carry=0; seq_cnt=1; busy low after.
//  A=8'hFF, B=8'h01, cmd=ADD -> data word 32'h100, carry=1, zero=1 in ctrl word.
//  cmd=4'hF in WAIT_B -> err=1, no wr_req; next btn_pulse -> IDLE, err=0.
//  wr_ack withheld in WR_DATA for ACK_TO cycles -> err=1 on expiry, wr_data stable throughout.
//  rst asserted mid-WR_CTRL -> next cycle wr_req=0, state IDLE, seq_cnt=0.
//  ALU_SEQ_ACC_EN: result 8'h10, then sw_acc=1 + B=8'h10 ADD -> data word 32'h020.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM states,
// register-bank select codes, status-word layout and ALU command codes.
package alu_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        EXEC,
        WR_DATA,
        WR_CTRL,
        ERR
    } seq_state_t;

    localparam logic SEL_CTRL = 1'b0;
    localparam logic SEL_DATA = 1'b1;

    // status word layout: {pad, seq[7:0], 2'b0, zero, carry, cmd[3:0]}
    localparam int ST_CMD_LSB   = 0;
    localparam int ST_CARRY_BIT = 4;
    localparam int ST_ZERO_BIT  = 5;
    localparam int ST_SEQ_LSB   = 8;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;
    localparam logic [3:0] ALU_INC = 4'd8;
    localparam logic [3:0] ALU_DEC = 4'd9;

    localparam int NUM_OPS = 10;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// ALU operand/result bus plus the req/ack register-bank write port.
// master = sequencer side, slave = ALU / register-bank side.
interface alu_cmd_sequencer_if #(
    parameter int N     = 8,
    parameter int REG_W = 32
);
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [3:0]       alu_ctrl;
    logic [N-1:0]     alu_result;
    logic             alu_carry;
    logic             wr_req;
    logic             wr_sel;
    logic [REG_W-1:0] wr_data;
    logic             wr_ack;

    modport master (
        output alu_a, alu_b, alu_ctrl, wr_req, wr_sel, wr_data,
        input  alu_result, alu_carry, wr_ack
    );

    modport slave (
        input  alu_a, alu_b, alu_ctrl, wr_req, wr_sel, wr_data,
        output alu_result, alu_carry, wr_ack
    );
endinterface

// File: rtl/alu_cmd_sequencer_seq_timeout_counter.sv
// Loadable down-counter; expire flags terminal count while enabled.
// Used for both the ALU latency wait and the write-ack timeout.
module seq_timeout_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] cnt_q, cnt_d;

    // load has priority; otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire = en && (cnt_q == '0);
endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: two button presses capture A then B+cmd, the ALU
// result is sampled after ALU_LAT cycles and written to the data bank, then a
// status word is written to the control bank.
// Optional feature macro ALU_SEQ_ACC_EN: sw_acc in IDLE reuses the previous
// result as operand A.
//
//  state   | meaning
//  IDLE    | waiting for operand A press
//  WAIT_B  | A captured, waiting for operand B + command press
//  EXEC    | operands on the ALU, waiting ALU_LAT cycles
//  WR_DATA | writing {carry,result} to the data bank
//  WR_CTRL | one idle cycle, then writing the status word to the control bank
//  ERR     | bad command or ack timeout, next press returns to IDLE
module alu_cmd_sequencer #(
    parameter int N       = 8,
    parameter int REG_W   = 32,
    parameter int ALU_LAT = 1,
    parameter int NUM_OPS = alu_cmd_sequencer_pkg::NUM_OPS,
    parameter int ACK_TO  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_pulse,
    input  logic [N-1:0]               sw_data,
    input  logic [3:0]                 sw_cmd,
    input  logic                       sw_acc,
    alu_cmd_sequencer_if.master        bus,
    output logic                       busy,
    output logic                       err,
    output logic [7:0]                 seq_cnt
);
    import alu_cmd_sequencer_pkg::*;

    localparam int CNT_W = $clog2(((ACK_TO > ALU_LAT) ? ACK_TO : ALU_LAT) + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TO - 1);

    seq_state_t       state_q, state_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [N:0]       res_q, res_d;
    logic [7:0]       seq_cnt_q, seq_cnt_d;
    logic             gap_q, gap_d;
    logic             tmr_load, tmr_en, tmr_exp;
    logic [CNT_W-1:0] tmr_val;
    logic [REG_W-1:0] ctrl_word;
    logic [N-1:0]     a_src;

`ifdef ALU_SEQ_ACC_EN
    assign a_src = sw_acc ? res_q[N-1:0] : sw_data;
`else
    logic unused_sw_acc;
    assign unused_sw_acc = sw_acc;
    assign a_src = sw_data;
`endif

    seq_timeout_counter #(.W(CNT_W)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .expire   (tmr_exp)
    );

    // next-state, operand capture and timer control
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cmd_d     = cmd_q;
        res_d     = res_q;
        seq_cnt_d = seq_cnt_q;
        gap_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = '0;
        case (state_q)
            IDLE: if (btn_pulse) begin
                a_d     = a_src;
                state_d = WAIT_B;
            end
            WAIT_B: if (btn_pulse) begin
                b_d      = sw_data;
                cmd_d    = sw_cmd;
                tmr_load = 1'b1;
                tmr_val  = LAT_LOAD;
                state_d  = (int'(sw_cmd) >= NUM_OPS) ? ERR : EXEC;
            end
            EXEC: begin
                tmr_en = 1'b1;
                if (tmr_exp) begin
                    res_d    = {bus.alu_carry, bus.alu_result};
                    tmr_load = 1'b1;
                    tmr_val  = ACK_LOAD;
                    state_d  = WR_DATA;
                end
            end
            WR_DATA: begin
                tmr_en = 1'b1;
                if (bus.wr_ack) begin
                    gap_d    = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = ACK_LOAD;
                    state_d  = WR_CTRL;
                end else if (tmr_exp) begin
                    state_d = ERR;
                end
            end
            WR_CTRL: if (!gap_q) begin
                tmr_en = 1'b1;
                if (bus.wr_ack) begin
                    seq_cnt_d = seq_cnt_q + 8'd1;
                    state_d   = IDLE;
                end else if (tmr_exp) begin
                    state_d = ERR;
                end
            end
            ERR: if (btn_pulse) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cmd_q     <= '0;
            res_q     <= '0;
            seq_cnt_q <= '0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cmd_q     <= cmd_d;
            res_q     <= res_d;
            seq_cnt_q <= seq_cnt_d;
            gap_q     <= gap_d;
        end
    end

    // status word for the control bank
    always_comb begin
        ctrl_word                       = '0;
        ctrl_word[ST_CMD_LSB +: 4]      = cmd_q;
        ctrl_word[ST_CARRY_BIT]         = res_q[N];
        ctrl_word[ST_ZERO_BIT]          = (res_q[N-1:0] == '0);
        ctrl_word[ST_SEQ_LSB +: 8]      = seq_cnt_q + 8'd1;
    end

    // bus outputs decoded from the registered state
    always_comb begin
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = '0;
        bus.wr_req   = 1'b0;
        bus.wr_sel   = SEL_CTRL;
        bus.wr_data  = '0;
        if (state_q inside {EXEC, WR_DATA, WR_CTRL}) begin
            bus.alu_a    = a_q;
            bus.alu_b    = b_q;
            bus.alu_ctrl = cmd_q;
        end
        if (state_q == WR_DATA) begin
            bus.wr_req  = 1'b1;
            bus.wr_sel  = SEL_DATA;
            bus.wr_data = REG_W'(res_q);
        end
        if (state_q == WR_CTRL) begin
            bus.wr_req  = !gap_q;
            bus.wr_data = ctrl_word;
        end
    end

    assign busy    = state_q inside {EXEC, WR_DATA, WR_CTRL};
    assign err     = (state_q == ERR);
    assign seq_cnt = seq_cnt_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: combinational ALU and ack-driving register bank
// modelled here, table vectors, corner-case sequences and random transactions.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int N       = 8;
    localparam int REG_W   = 32;
    localparam int ALU_LAT = 1;
    localparam int ACK_TO  = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_pulse = 1'b0;
    logic       sw_acc = 1'b0;
    logic [7:0] sw_data = '0;
    logic [3:0] sw_cmd = '0;
    logic       busy, err;
    logic [7:0] seq_cnt;

    int total = 0;
    int bad   = 0;
    int model_seq = 0;
    logic [8:0] last_res = '0;

    alu_cmd_sequencer_if #(.N(N), .REG_W(REG_W)) bus();

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .N(N), .REG_W(REG_W), .ALU_LAT(ALU_LAT), .NUM_OPS(10), .ACK_TO(ACK_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pulse (btn_pulse),
        .sw_data   (sw_data),
        .sw_cmd    (sw_cmd),
        .sw_acc    (sw_acc),
        .bus       (bus),
        .busy      (busy),
        .err       (err),
        .seq_cnt   (seq_cnt)
    );

    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] op);
        case (op)
            ALU_ADD: return {1'b0, a} + {1'b0, b};
            ALU_SUB: return {1'b0, a} - {1'b0, b};
            ALU_AND: return {1'b0, a & b};
            ALU_OR:  return {1'b0, a | b};
            ALU_XOR: return {1'b0, a ^ b};
            ALU_NOT: return {1'b0, ~a};
            ALU_SHL: return {a, 1'b0};
            ALU_SHR: return {2'b00, a[7:1]};
            ALU_INC: return {1'b0, a} + 9'd1;
            ALU_DEC: return {1'b0, a} - 9'd1;
            default: return '0;
        endcase
    endfunction

    always_comb {bus.alu_carry, bus.alu_result} = alu_model(bus.alu_a, bus.alu_b, bus.alu_ctrl);

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  cmd;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d, input logic [3:0] c, input logic acc);
        sw_data   = d;
        sw_cmd    = c;
        sw_acc    = acc;
        btn_pulse = 1'b1;
        tick;
        btn_pulse = 1'b0;
        sw_acc    = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (bus.wr_req !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
    endtask

    // full transaction with a model-derived (or table-given) expected data word
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                          input logic acc, input int dly_d, input int dly_c,
                          input logic use_tbl, input logic [31:0] tbl_data);
        logic [7:0]  a_eff;
        logic [31:0] exp_d, exp_c;
        int          n;
        logic        ok;
        a_eff = a;
`ifdef ALU_SEQ_ACC_EN
        if (acc) a_eff = last_res[7:0];
`endif
        pulse(a, 4'd0, acc);
        check("waitb_busy", busy, 0);
        pulse(b, cmd, 1'b0);
        if (int'(cmd) >= NUM_OPS) begin
            check("inv_err", err, 1);
            check("inv_req", bus.wr_req, 0);
            check("inv_busy", busy, 0);
            tick;
            check("inv_req_hold", bus.wr_req, 0);
            check("inv_err_hold", err, 1);
            pulse(8'hA5, 4'd0, 1'b0);
            check("inv_clear", err, 0);
        end else begin
            check("exec_a", bus.alu_a, a_eff);
            check("exec_b", bus.alu_b, b);
            check("exec_ctrl", bus.alu_ctrl, cmd);
            check("exec_busy", busy, 1);
            wait_req(n);
            check("req_latency", n, ALU_LAT);
            exp_d = use_tbl ? tbl_data : {23'b0, alu_model(a_eff, b, cmd)};
            exp_c = {16'b0, 8'(model_seq + 1), 2'b00, (exp_d[7:0] == 8'h00), exp_d[8], cmd};
            check("data_sel", bus.wr_sel, SEL_DATA);
            check("data_word", bus.wr_data, exp_d);
            ok = 1'b1;
            for (int i = 0; i < dly_d; i++) begin
                tick;
                if (bus.wr_req !== 1'b1 || bus.wr_data !== exp_d) ok = 1'b0;
            end
            if (dly_d > 0) check("data_hold", ok, 1);
            bus.wr_ack = 1'b1;
            tick;
            bus.wr_ack = 1'b0;
            check("gap_req", bus.wr_req, 0);
            check("gap_busy", busy, 1);
            tick;
            check("ctrl_req", bus.wr_req, 1);
            check("ctrl_sel", bus.wr_sel, SEL_CTRL);
            check("ctrl_word", bus.wr_data, exp_c);
            ok = 1'b1;
            for (int i = 0; i < dly_c; i++) begin
                tick;
                if (bus.wr_req !== 1'b1 || bus.wr_data !== exp_c) ok = 1'b0;
            end
            if (dly_c > 0) check("ctrl_hold", ok, 1);
            bus.wr_ack = 1'b1;
            tick;
            bus.wr_ack = 1'b0;
            model_seq = (model_seq + 1) % 256;
            last_res  = exp_d[8:0];
            check("done_busy", busy, 0);
            check("done_req", bus.wr_req, 0);
            check("seq_cnt", seq_cnt, model_seq);
        end
    endtask

    // drive A then B+cmd and stop at the first WR_DATA request cycle
    task automatic to_wr_data(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd);
        int n;
        pulse(a, 4'd0, 1'b0);
        pulse(b, cmd, 1'b0);
        wait_req(n);
        check("to_wr_req", bus.wr_req, 1);
        last_res = alu_model(a, b, cmd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rc;
        logic       ok;

        bus.wr_ack = 1'b0;
        vecs[0]  = '{8'h0F, 8'h01, ALU_ADD, 32'h010};
        vecs[1]  = '{8'hFF, 8'h01, ALU_ADD, 32'h100};
        vecs[2]  = '{8'h05, 8'h07, ALU_SUB, 32'h1FE};
        vecs[3]  = '{8'hF0, 8'h0F, ALU_AND, 32'h000};
        vecs[4]  = '{8'hF0, 8'h0F, ALU_OR,  32'h0FF};
        vecs[5]  = '{8'hAA, 8'hFF, ALU_XOR, 32'h055};
        vecs[6]  = '{8'h0F, 8'h33, ALU_NOT, 32'h0F0};
        vecs[7]  = '{8'h81, 8'h00, ALU_SHL, 32'h102};
        vecs[8]  = '{8'h81, 8'h00, ALU_SHR, 32'h040};
        vecs[9]  = '{8'hFF, 8'h00, ALU_INC, 32'h100};
        vecs[10] = '{8'h00, 8'h00, ALU_DEC, 32'h1FF};

        tick;
        tick;
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_seq", seq_cnt, 0);
        check("rst_req", bus.wr_req, 0);
        rst = 1'b0;
        tick;
        check("idle_busy", busy, 0);
        check("idle_req", bus.wr_req, 0);
        check("idle_alu_a", bus.alu_a, 0);
        check("idle_data", bus.wr_data, 0);

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cmd, 1'b0, i % 3, (i + 1) % 3, 1'b1, vecs[i].exp_data);

        // bad command, then the clearing press must not capture anything
        run_op(8'h12, 8'h34, 4'hF, 1'b0, 0, 0, 1'b0, 32'h0);
        run_op(8'h21, 8'h02, ALU_ADD, 1'b0, 0, 0, 1'b1, 32'h023);

        // ack withheld on the data write
        to_wr_data(8'h12, 8'h34, ALU_ADD);
        ok = 1'b1;
        for (int i = 0; i < ACK_TO; i++) begin
            if (bus.wr_req !== 1'b1 || bus.wr_data !== 32'h046 || err !== 1'b0) ok = 1'b0;
            tick;
        end
        check("tmo_data_stable", ok, 1);
        check("tmo_data_err", err, 1);
        check("tmo_data_req", bus.wr_req, 0);
        pulse(8'h00, 4'd0, 1'b0);
        check("tmo_data_clear", err, 0);

        // ack withheld on the status write
        to_wr_data(8'h40, 8'h01, ALU_SUB);
        bus.wr_ack = 1'b1;
        tick;
        bus.wr_ack = 1'b0;
        tick;
        ok = 1'b1;
        for (int i = 0; i < ACK_TO; i++) begin
            if (bus.wr_req !== 1'b1 || bus.wr_sel !== SEL_CTRL || err !== 1'b0) ok = 1'b0;
            tick;
        end
        check("tmo_ctrl_stable", ok, 1);
        check("tmo_ctrl_err", err, 1);
        check("tmo_ctrl_seq", seq_cnt, model_seq);
        pulse(8'h00, 4'd0, 1'b0);
        check("tmo_ctrl_clear", err, 0);

`ifdef ALU_SEQ_ACC_EN
        run_op(8'h08, 8'h08, ALU_ADD, 1'b0, 0, 0, 1'b1, 32'h010);
        run_op(8'h5A, 8'h10, ALU_ADD, 1'b1, 1, 0, 1'b1, 32'h020);
`endif

        // reset during the status write
        to_wr_data(8'h33, 8'h11, ALU_SUB);
        bus.wr_ack = 1'b1;
        tick;
        bus.wr_ack = 1'b0;
        tick;
        check("rst_pre_req", bus.wr_req, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_mid_req", bus.wr_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_seq", seq_cnt, 0);
        check("rst_mid_err", err, 0);
        model_seq = 0;
        last_res  = '0;

        // random transactions, long enough to wrap seq_cnt
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = (i % 12 == 5) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            run_op(ra, rb, rc, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'b0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
